// File: rtl/prog_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader_pkg
// Description : Shared types and constants for the framed program loader.
//               Holds the parser state encoding, the error-code encoding and
//               the frame sync byte.
// Revision    : 1.0 - initial release
// ============================================================================
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHK    = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_LEN     = 2'd1,
    ERR_CHK     = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_e;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // States in which a frame is being received (CPU held, timeout armed).
  function automatic logic in_frame(state_e s);
    return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA) || (s == ST_CHK);
  endfunction

endpackage
`default_nettype wire

// File: rtl/prog_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader_if
// Description : Bundle of the loader's byte input and RAM/status outputs.
//   rx_valid/rx_data           : byte strobe and data from the UART receiver
//   prog_we/prog_addr/prog_din : byte-write port of the program RAM
//   cpu_hold                   : CPU reset request while a frame is loading
//   load_done/load_err/err_code: completion pulse and sticky error report
//   modport master : the loader (drives RAM and status)
//   modport slave  : the surrounding system (drives the byte stream)
// Revision    : 1.0 - initial release
// ============================================================================
interface prog_loader_if #(
  parameter int MEM_SIZE = 32767
);
  localparam int ADDRW = $clog2(MEM_SIZE);

  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             prog_we;
  logic [ADDRW-1:0] prog_addr;
  logic [7:0]       prog_din;
  logic             cpu_hold;
  logic             load_done;
  logic             load_err;
  logic [1:0]       err_code;

  modport master (
    input  rx_valid, rx_data,
    output prog_we, prog_addr, prog_din, cpu_hold, load_done, load_err, err_code
  );

  modport slave (
    output rx_valid, rx_data,
    input  prog_we, prog_addr, prog_din, cpu_hold, load_done, load_err, err_code
  );

endinterface
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Parses a framed byte stream (SYNC, LEN_LO, LEN_HI, payload,
//               CHK) and writes the payload to program RAM from address 0,
//               holding the CPU in reset while a frame is in progress.
//   clk   : single clock, all logic on posedge
//   rst_n : asynchronous active-low reset
//   bus   : prog_loader_if.master (byte input, RAM write port, status)
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int MEM_SIZE       = 32767,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic          clk,
  input  logic          rst_n,
  prog_loader_if.master bus
);

  localparam int ADDRW = $clog2(MEM_SIZE);
  localparam int TW    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]   MAX_LEN  = 17'(MEM_SIZE + 1);

  state_e           state_q, state_d;
  logic [ADDRW-1:0] addr_q, addr_d;
  logic [15:0]      remain_q, remain_d;
  logic [7:0]       len_lo_q, len_lo_d;
  logic [7:0]       sum_q, sum_d;
  logic [TW-1:0]    tmo_q, tmo_d;

  logic             prog_we_q, prog_we_d;
  logic [ADDRW-1:0] prog_addr_q, prog_addr_d;
  logic [7:0]       prog_din_q, prog_din_d;
  logic             cpu_hold_q, cpu_hold_d;
  logic             load_done_q, load_done_d;
  logic             load_err_q, load_err_d;
  err_e             err_code_q, err_code_d;

  logic [15:0]      len_w;
  assign len_w = {bus.rx_data, len_lo_q};

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remain_d    = remain_q;
    len_lo_d    = len_lo_q;
    sum_d       = sum_q;
    tmo_d       = tmo_q;
    prog_we_d   = 1'b0;
    prog_addr_d = prog_addr_q;
    prog_din_d  = prog_din_q;
    load_err_d  = load_err_q;
    err_code_d  = err_code_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.rx_valid && (bus.rx_data == SYNC_BYTE)) begin
          state_d    = ST_LEN_LO;
          load_err_d = 1'b0;
          err_code_d = ERR_NONE;
          addr_d     = '0;
          sum_d      = '0;
        end
      end
      ST_LEN_LO: begin
        if (bus.rx_valid) begin
          len_lo_d = bus.rx_data;
          state_d  = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (bus.rx_valid) begin
          if ({1'b0, len_w} > MAX_LEN) begin
            state_d    = ST_ERR;
            err_code_d = ERR_LEN;
          end else if (len_w == 16'd0) begin
            state_d = ST_CHK;
          end else begin
            state_d  = ST_DATA;
            remain_d = len_w;
          end
        end
      end
      ST_DATA: begin
        if (bus.rx_valid) begin
          prog_we_d   = 1'b1;
          prog_addr_d = addr_q;
          prog_din_d  = bus.rx_data;
          // Wraps only after the final byte of a maximum-length frame.
          addr_d      = addr_q + ADDRW'(1);
          sum_d       = sum_q + bus.rx_data;
          remain_d    = remain_q - 16'd1;
          if (remain_q == 16'd1) begin
            state_d = ST_CHK;
          end
        end
      end
      ST_CHK: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == sum_q) begin
            state_d = ST_DONE;
          end else begin
            state_d    = ST_ERR;
            err_code_d = ERR_CHK;
          end
        end
      end
      default: begin
        // DONE and ERR last one cycle; any byte arriving now is dropped.
        state_d = ST_IDLE;
      end
    endcase

    // Inter-byte watchdog. A byte arriving on the expiry cycle wins.
    if (in_frame(state_q)) begin
      if (bus.rx_valid) begin
        tmo_d = '0;
      end else if (tmo_q == TMO_LAST) begin
        state_d    = ST_ERR;
        err_code_d = ERR_TIMEOUT;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end else begin
      tmo_d = '0;
    end

    // Status outputs are registered copies of the next-state decode so they
    // align with the state they describe.
    cpu_hold_d  = in_frame(state_d);
    load_done_d = (state_d == ST_DONE);
    if (state_d == ST_ERR) begin
      load_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remain_q    <= '0;
      len_lo_q    <= '0;
      sum_q       <= '0;
      tmo_q       <= '0;
      prog_we_q   <= 1'b0;
      prog_addr_q <= '0;
      prog_din_q  <= '0;
      cpu_hold_q  <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remain_q    <= remain_d;
      len_lo_q    <= len_lo_d;
      sum_q       <= sum_d;
      tmo_q       <= tmo_d;
      prog_we_q   <= prog_we_d;
      prog_addr_q <= prog_addr_d;
      prog_din_q  <= prog_din_d;
      cpu_hold_q  <= cpu_hold_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign bus.prog_we   = prog_we_q;
  assign bus.prog_addr = prog_addr_q;
  assign bus.prog_din  = prog_din_q;
  assign bus.cpu_hold  = cpu_hold_q;
  assign bus.load_done = load_done_q;
  assign bus.load_err  = load_err_q;
  assign bus.err_code  = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_loader
// Description : Self-checking bench for prog_loader. Directed frames from the
//               frame format plus randomized frames checked against a
//               byte-stream parsing model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prog_loader_if bus ();

  prog_loader #(.MEM_SIZE(32767), .TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int checks = 0;
  int errors = 0;

  // Observed RAM writes {addr, data} and load_done pulses.
  logic [23:0] got_wr[$];
  int          done_cnt;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.prog_we) got_wr.push_back({16'(bus.prog_addr), bus.prog_din});
      if (bus.load_done) done_cnt++;
    end
  end

  // Reference model results.
  logic [23:0] exp_wr[$];
  int          exp_done;
  int          exp_err;
  logic [7:0]  stim[$];

  // Parse one frame from a byte list by the frame rules.
  function automatic void model(input logic [7:0] s[$]);
    int i, len;
    logic [7:0] sum;
    exp_wr.delete(); exp_done = 0; exp_err = 0; i = 0; sum = 8'd0;
    while (i < s.size() && s[i] != 8'hA5) i++;
    if (i + 2 >= s.size()) return;
    len = int'(s[i+1]) + 256 * int'(s[i+2]);
    i += 3;
    if (len > 32768) begin exp_err = 1; return; end
    for (int k = 0; k < len; k++) begin
      exp_wr.push_back({16'(k), s[i+k]});
      sum = sum + s[i+k];
    end
    if (i + len >= s.size()) return;
    if (s[i+len] == sum) exp_done = 1; else exp_err = 2;
  endfunction

  // Build a frame into stim: optional junk, header, payload, checksum.
  function automatic void gen_frame(input int len, input bit bad, input int junk);
    logic [7:0] sum, b;
    stim.delete(); sum = 8'd0;
    for (int j = 0; j < junk; j++) begin
      b = 8'($urandom);
      if (b == 8'hA5) b = 8'h00;
      stim.push_back(b);
    end
    stim.push_back(8'hA5);
    stim.push_back(8'(len));
    stim.push_back(8'(len >> 8));
    if (len <= 32768) begin
      for (int j = 0; j < len; j++) begin
        b = 8'($urandom);
        stim.push_back(b);
        sum = sum + b;
      end
      stim.push_back(bad ? sum ^ 8'(1 + $urandom_range(0, 254)) : sum);
    end
  endfunction

  task automatic send(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_stim(input int maxgap);
    foreach (stim[j]) begin
      send(stim[j]);
      repeat ($urandom_range(0, maxgap)) @(negedge clk);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic clear_log();
    got_wr.delete();
    done_cnt = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (bus.prog_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", bus.prog_we); end
    checks++; if (bus.prog_addr !== 15'd0) begin errors++; $display("FAIL reset_addr got %0h want 0", bus.prog_addr); end
    checks++; if (bus.prog_din !== 8'd0) begin errors++; $display("FAIL reset_din got %0h want 0", bus.prog_din); end
    checks++; if (bus.cpu_hold !== 1'b0) begin errors++; $display("FAIL reset_hold got %b want 0", bus.cpu_hold); end
    checks++; if (bus.load_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.load_done); end
    checks++; if (bus.load_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus.load_err); end
    checks++; if (bus.err_code !== 2'd0) begin errors++; $display("FAIL reset_code got %0d want 0", bus.err_code); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    clear_log();
    send(8'hA5);
    checks++; if (bus.cpu_hold !== 1'b1) begin errors++; $display("FAIL basic_hold_on got %b want 1", bus.cpu_hold); end
    send(8'h03); send(8'h00);
    send(8'h11);
    checks++; if ({bus.prog_we, bus.prog_addr, bus.prog_din} !== {1'b1, 15'd0, 8'h11}) begin
      errors++; $display("FAIL basic_first_write got we=%b a=%0h d=%0h want we=1 a=0 d=11", bus.prog_we, bus.prog_addr, bus.prog_din); end
    send(8'h22); send(8'h33);
    @(negedge clk);
    checks++; if ({bus.prog_we, bus.prog_addr, bus.prog_din} !== {1'b0, 15'd2, 8'h33}) begin
      errors++; $display("FAIL basic_hold_bus got we=%b a=%0h d=%0h want we=0 a=2 d=33", bus.prog_we, bus.prog_addr, bus.prog_din); end
    send(8'h66);
    checks++; if ({bus.load_done, bus.cpu_hold} !== 2'b10) begin
      errors++; $display("FAIL basic_done_edge got done=%b hold=%b want done=1 hold=0", bus.load_done, bus.cpu_hold); end
    repeat (3) @(negedge clk);
    checks++; if (got_wr.size() !== 3) begin errors++; $display("FAIL basic_nwr got %0d want 3", got_wr.size()); end
    else begin
      checks++; if ({got_wr[0], got_wr[1], got_wr[2]} !== {24'h000011, 24'h000122, 24'h000233}) begin
        errors++; $display("FAIL basic_wr got %h %h %h want 000011 000122 000233", got_wr[0], got_wr[1], got_wr[2]); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done_cnt got %0d want 1", done_cnt); end
    checks++; if (bus.load_err !== 1'b0) begin errors++; $display("FAIL basic_err got %b want 0", bus.load_err); end
  endtask

  task automatic test_zero_len();
    clear_log();
    send(8'h00); send(8'h7F); send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
    checks++; if (bus.load_done !== 1'b1) begin errors++; $display("FAIL zero_done got %b want 1", bus.load_done); end
    repeat (3) @(negedge clk);
    checks++; if (got_wr.size() !== 0) begin errors++; $display("FAIL zero_nwr got %0d want 0", got_wr.size()); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL zero_done_cnt got %0d want 1", done_cnt); end
  endtask

  task automatic test_chk_err();
    clear_log();
    send(8'hA5); send(8'h02); send(8'h00); send(8'h10); send(8'h20); send(8'h31);
    checks++; if ({bus.load_err, bus.err_code, bus.cpu_hold} !== {1'b1, 2'd2, 1'b0}) begin
      errors++; $display("FAIL chk_err got err=%b code=%0d hold=%b want 1 2 0", bus.load_err, bus.err_code, bus.cpu_hold); end
    repeat (10) @(negedge clk);
    send(8'h00);
    checks++; if ({bus.load_err, bus.err_code} !== {1'b1, 2'd2}) begin
      errors++; $display("FAIL chk_sticky got err=%b code=%0d want 1 2", bus.load_err, bus.err_code); end
    checks++; if (got_wr.size() !== 2 || got_wr[0] !== 24'h000010 || got_wr[1] !== 24'h000120) begin
      errors++; $display("FAIL chk_writes got n=%0d want 2 writes 000010 000120", got_wr.size()); end
    send(8'hA5);
    checks++; if ({bus.load_err, bus.err_code, bus.cpu_hold} !== {1'b0, 2'd0, 1'b1}) begin
      errors++; $display("FAIL chk_clear got err=%b code=%0d hold=%b want 0 0 1", bus.load_err, bus.err_code, bus.cpu_hold); end
    send(8'h00); send(8'h00); send(8'h00);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_len_err();
    clear_log();
    send(8'hA5); send(8'h01); send(8'h81);
    checks++; if ({bus.load_err, bus.err_code, bus.cpu_hold} !== {1'b1, 2'd1, 1'b0}) begin
      errors++; $display("FAIL len_err got err=%b code=%0d hold=%b want 1 1 0", bus.load_err, bus.err_code, bus.cpu_hold); end
    repeat (4) @(negedge clk);
    checks++; if (got_wr.size() !== 0) begin errors++; $display("FAIL len_nwr got %0d want 0", got_wr.size()); end
  endtask

  task automatic test_timeout();
    int n;
    clear_log();
    send(8'hA5); send(8'h02); send(8'h00); send(8'h10);
    n = 0;
    while (bus.load_err !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n < TMO - 1 || n > TMO + 1) begin errors++; $display("FAIL tmo_latency got %0d cycles want about %0d", n, TMO); end
    checks++; if ({bus.err_code, bus.cpu_hold} !== {2'd3, 1'b0}) begin
      errors++; $display("FAIL tmo_code got code=%0d hold=%b want 3 0", bus.err_code, bus.cpu_hold); end
    repeat (2) @(negedge clk);
    checks++; if (got_wr.size() !== 1) begin errors++; $display("FAIL tmo_nwr got %0d want 1", got_wr.size()); end
    clear_log();
    gen_frame(5, 1'b0, 0);
    model(stim);
    send_stim(2);
    checks++; if (done_cnt !== exp_done || got_wr.size() !== exp_wr.size()) begin
      errors++; $display("FAIL tmo_recover got done=%0d nwr=%0d want done=%0d nwr=%0d", done_cnt, got_wr.size(), exp_done, exp_wr.size()); end
    checks++; if ({bus.load_err, bus.err_code} !== 3'b000) begin
      errors++; $display("FAIL tmo_recover_err got err=%b code=%0d want 0 0", bus.load_err, bus.err_code); end
  endtask

  task automatic test_random(input string name, input int iters, input int maxgap);
    int len, sel;
    for (int it = 0; it < iters; it++) begin
      clear_log();
      sel = $urandom_range(0, 9);
      if (sel == 0) len = 0;
      else if (sel == 1) len = 32769 + $urandom_range(0, 30000);
      else len = $urandom_range(1, 48);
      gen_frame(len, $urandom_range(0, 3) == 0, $urandom_range(0, 3));
      model(stim);
      send_stim(maxgap);
      checks++; if (got_wr.size() !== exp_wr.size()) begin
        errors++; $display("FAIL %s_nwr it=%0d got %0d want %0d", name, it, got_wr.size(), exp_wr.size()); end
      else begin
        foreach (exp_wr[k]) begin
          checks++; if (got_wr[k] !== exp_wr[k]) begin
            errors++; $display("FAIL %s_wr it=%0d idx=%0d got %h want %h", name, it, k, got_wr[k], exp_wr[k]); end
        end
      end
      checks++; if (done_cnt !== exp_done) begin
        errors++; $display("FAIL %s_done it=%0d got %0d want %0d", name, it, done_cnt, exp_done); end
      checks++; if ({bus.load_err, bus.err_code} !== {exp_err != 0, 2'(exp_err)}) begin
        errors++; $display("FAIL %s_err it=%0d got err=%b code=%0d want code=%0d", name, it, bus.load_err, bus.err_code, exp_err); end
      checks++; if (bus.cpu_hold !== 1'b0) begin
        errors++; $display("FAIL %s_hold it=%0d got %b want 0", name, it, bus.cpu_hold); end
    end
  endtask

  task automatic test_reset_mid();
    clear_log();
    send(8'hA5); send(8'h20); send(8'h00);
    for (int j = 0; j < 5; j++) send(8'($urandom_range(1, 255)));
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({bus.cpu_hold, bus.prog_we, bus.load_done, bus.load_err} !== 4'b0000) begin
      errors++; $display("FAIL rstmid_flags got hold=%b we=%b done=%b err=%b want 0", bus.cpu_hold, bus.prog_we, bus.load_done, bus.load_err); end
    checks++; if ({bus.prog_addr, bus.prog_din, bus.err_code} !== 25'd0) begin
      errors++; $display("FAIL rstmid_bus got a=%0h d=%0h code=%0d want 0", bus.prog_addr, bus.prog_din, bus.err_code); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_log();
    send(8'hA5); send(8'h02); send(8'h00); send(8'hAB); send(8'hCD); send(8'h78);
    repeat (3) @(negedge clk);
    checks++; if (got_wr.size() !== 2 || got_wr[0] !== 24'h0000AB || got_wr[1] !== 24'h0001CD) begin
      errors++; $display("FAIL rstmid_writes got n=%0d want 0000AB 0001CD", got_wr.size()); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL rstmid_done got %0d want 1", done_cnt); end
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    done_cnt     = 0;
    test_reset();
    test_basic();
    test_zero_len();
    test_chk_err();
    test_len_err();
    test_timeout();
    test_random("random", 25, 3);
    test_random("back_to_back", 6, 0);
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/prog_loader.md
# prog_loader

Byte-stream program loader sitting directly upstream of the byte-write program RAM. Consumes bytes from the UART receiver, parses a framed image (sync, length, payload, checksum), writes each payload byte to consecutive RAM addresses from 0 and holds the CPU in reset while loading. Reports completion or a coded error.

## Interface
- `MEM_SIZE`, 32767: highest RAM byte index; RAM holds MEM_SIZE+1 bytes.
- `ADDRW`, $clog2(MEM_SIZE) (localparam): program RAM address width (15 at default).
- `TIMEOUT_CYCLES`, 1_000_000: maximum idle clocks between bytes inside a frame.

- `clk` in 1: single clock; all logic on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx_valid` in 1: one-cycle strobe, new byte on `rx_data`.
- `rx_data` in 8: received byte.
- `prog_we` out 1: RAM byte write enable, one cycle per payload byte.
- `prog_addr` out ADDRW: RAM byte address.
- `prog_din` out 8: RAM write data.
- `cpu_hold` out 1: high while a frame is in progress; drives CPU reset.
- `load_done` out 1: one-cycle pulse on successful frame.
- `load_err` out 1: sticky error flag, cleared when next SYNC is accepted.
- `err_code` out 2: 0 none, 1 length too large, 2 checksum mismatch, 3 timeout; held with `load_err`.

## Operation
- Frame: SYNC (0xA5), LEN_LO, LEN_HI, N payload bytes (N = {LEN_HI,LEN_LO}), CHK = sum of payload bytes mod 256.
- States: IDLE, LEN_LO, LEN_HI, DATA, CHK, DONE, ERR.
- IDLE: rx_valid with 0xA5 → LEN_LO, clear load_err/err_code, addr←0, sum←0. Other bytes ignored.
- LEN_LO → LEN_HI on rx_valid. LEN_HI on rx_valid: N > MEM_SIZE+1 → ERR code 1; N = 0 → CHK; else → DATA.
- DATA: each rx_valid writes byte to addr, sum += byte, addr++, remaining--; last byte → CHK.
- CHK: rx_valid byte == sum → DONE, else ERR code 2.
- DONE, ERR: one cycle each, then IDLE. DONE pulses load_done; ERR sets load_err/err_code.
- Timeout: counter cleared on every rx_valid and on entering LEN_LO; counts in LEN_LO..CHK; reaching TIMEOUT_CYCLES-1 without a byte → ERR code 3.
- cpu_hold = 1 in LEN_LO, LEN_HI, DATA, CHK; 0 in IDLE, DONE, ERR. RAM contents written before an error are not rolled back.
- Sum and length arithmetic: 8-bit wrapping sum; 16-bit remaining counter; addr never exceeds MEM_SIZE (guaranteed by length check).

## Timing
- Reset values: prog_we 0, prog_addr 0, prog_din 0, cpu_hold 0, load_done 0, load_err 0, err_code 0, state IDLE.
- All outputs registered. Payload byte accepted at cycle t → prog_we=1 with addr/din valid at cycle t+1, for exactly one cycle. RAM captures on the following negedge (half-cycle setup).
- Back-to-back rx_valid every cycle supported; one write per cycle.
- prog_addr and prog_din hold last written values when prog_we=0.
- Last payload at t, CHK at t+k → load_done high at t+k+1, cpu_hold falls same cycle.
- rx_valid in DONE/ERR is ignored (includes SYNC).
- Reset mid-frame: immediate return to reset values; cpu_hold drops asynchronously.

## Structure
- Package `prog_loader_pkg`: state enum, err_code enum (ERR_NONE, ERR_LEN, ERR_CHK, ERR_TIMEOUT), SYNC_BYTE = 8'hA5.
- Single module, no sub-module; timeout counter inline.

## Test plan
- Bytes A5 03 00 11 22 33 66 → writes 11@0, 22@1, 33@2, one load_done pulse, load_err 0, cpu_hold high from after A5 to done.
- Bytes 00 7F A5 00 00 00 → leading junk ignored, zero-length frame, load_done, no prog_we.
- A5 02 00 10 20 31 → ERR code 2, load_err held until next A5 accepted, two writes already performed.
- A5 01 81 → N=0x8101 > 32768 → ERR code 1 immediately, no writes.
- A5 02 00 10 then silence TIMEOUT_CYCLES (bench with 16) → ERR code 3, cpu_hold 0; following full frame succeeds and clears err.
- rst_n low mid-DATA then clean frame → outputs at reset values; new frame writes from addr 0.
